// File: rtl/flow_ctrl_pkg.sv
// Shared flow-control definitions: default buffer geometry and the occupancy-state
// encoding reused by the flow-control block family.
package flow_ctrl_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_DEPTH     = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_e;

endpackage : flow_ctrl_pkg

// File: rtl/flow_ctrl_regfile.sv
// DEPTH x DATA_SIZE storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module flow_ctrl_regfile
    import flow_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : flow_ctrl_regfile

// File: rtl/flow_ctrl_skid_fifo.sv
// DEPTH-entry valid/ready elastic buffer with occupancy output.
// Optional FLOW_CTRL_BYPASS_EN adds a zero-latency path when the buffer is empty.
module flow_ctrl_skid_fifo
    import flow_ctrl_pkg::*;
#(
    parameter  int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 Valid_i,
    output logic                 Ready_o,
    input  logic [DATA_SIZE-1:0] Data_i,
    output logic                 Valid_o,
    input  logic                 Ready_i,
    output logic [DATA_SIZE-1:0] Data_o,
    output logic [ADDR_W:0]      Count_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    occ_state_e            state_q, state_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_SIZE-1:0]  rdata;
    logic                  store_valid;
    logic                  push, pop, wr_en, rd_en;

    // Ready_o depends only on registered state, never on Ready_i.
    assign store_valid = (state_q != EMPTY);
    assign Ready_o     = (state_q != FULL);
    assign push        = Valid_i & Ready_o;
    assign pop         = Valid_o & Ready_i;
    assign rd_en       = pop & store_valid;

`ifdef FLOW_CTRL_BYPASS_EN
    logic bypass;
    assign bypass  = (state_q == EMPTY) & Valid_i;
    assign Valid_o = store_valid | bypass;
    assign Data_o  = bypass ? Data_i : rdata;
    // A bypassed beat taken downstream the same cycle never touches storage.
    assign wr_en   = push & ~(bypass & Ready_i);
`else
    assign Valid_o = store_valid;
    assign Data_o  = rdata;
    assign wr_en   = push;
`endif

    flow_ctrl_regfile #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (Data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    count_d = ONE_CNT;
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (wr_en && !rd_en) begin
                    count_d = count_q + ONE_CNT;
                    state_d = ((count_q + ONE_CNT) == FULL_CNT) ? FULL : PARTIAL;
                end else if (rd_en && !wr_en) begin
                    count_d = count_q - ONE_CNT;
                    state_d = ((count_q - ONE_CNT) == '0) ? EMPTY : PARTIAL;
                end
            end
            FULL: begin
                if (rd_en) begin
                    count_d = count_q - ONE_CNT;
                    state_d = PARTIAL;
                end
            end
            default: begin
                count_d = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign Count_o = count_q;

endmodule : flow_ctrl_skid_fifo

// File: doc/flow_ctrl_skid_fifo.md
Name: flow_ctrl_skid_fifo

Overview:
Parametrised successor to the single-stage valid/ready flow-control register. It provides a DEPTH-entry elastic buffer between an upstream producer and a downstream consumer, with the same Valid/Ready/Data handshake on both sides. It sustains full throughput (one beat per clock), absorbs downstream stalls without data loss, and reports its occupancy. It is used wherever a pipeline stage needs more than one beat of slack.

Parameters:
DATA_SIZE, 8, width of Data_i/Data_o in bits
DEPTH, 4, number of storage entries; power of 2, minimum 2
ADDR_W, $clog2(DEPTH), local parameter; pointer width, not overridable

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET_n  input  1  asynchronous active-low reset
Valid_i  input  1  upstream beat valid
Ready_o  output  1  block can accept a beat this cycle
Data_i  input  DATA_SIZE  upstream data
Valid_o  output  1  downstream beat valid
Ready_i  input  1  downstream accepts a beat this cycle
Data_o  output  DATA_SIZE  downstream data
Count_o  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset is asynchronous and active-low: RESET_n=0 immediately clears wr_ptr, rd_ptr and count to 0. Outputs during and after reset: Valid_o=0, Ready_o=1, Count_o=0. Data_o is don't-care while Valid_o=0. Storage contents are not reset.
- push = Valid_i & Ready_o; pop = Valid_o & Ready_i. Each side completes a transfer only on a cycle where both valid and ready are high.
- Occupancy FSM, derived from count:
  - EMPTY (count=0): push -> PARTIAL.
  - PARTIAL (0<count<DEPTH): push only -> count+1, entering FULL when count+1=DEPTH; pop only -> count-1, entering EMPTY when count-1=0; push and pop together -> count unchanged.
  - FULL (count=DEPTH): pop -> PARTIAL.
- Ready_o = (count != DEPTH). It is a register-derived signal with no combinational path from Ready_i. When FULL, a push is refused even if a pop happens in the same cycle.
- Valid_o = (count != 0). Data_o = mem[rd_ptr], read combinationally from storage.
- Latency: a beat pushed at edge N appears on Valid_o/Data_o after edge N (one-cycle latency) when the buffer was empty.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Count_o is the count register.
- Data order is strict FIFO. No beat is dropped or duplicated.
- Valid_i rising with Ready_o=0 does not change state. The upstream must hold Data_i until accepted; the block does not check this.
- Reset asserted mid-burst discards all stored beats. The first post-reset push is written to entry 0.

Optional Feature:
Macro FLOW_CTRL_BYPASS_EN.
- Defined: when count=0 and Valid_i=1, Valid_o=1 and Data_o=Data_i combinationally. If Ready_i=1 on that cycle, the beat is consumed directly: not written, count stays 0, zero latency. If Ready_i=0, the beat is written normally.
- Not defined: no combinational Valid_i->Valid_o or Data_i->Data_o path, and latency is always at least 1 cycle.

Decomposition:
- Shared package flow_ctrl_pkg holds: default DATA_SIZE/DEPTH constants, and an occupancy-state typedef/localparams (EMPTY, PARTIAL, FULL) reused by later flow-control blocks.
- One natural sub-module, flow_ctrl_regfile: DEPTH x DATA_SIZE register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). It has no reset.

Test Plan:
- Reset then idle: RESET_n low 10ns, Valid_i=0 -> Valid_o=0, Ready_o=1, Count_o=0 throughout.
- Fill without draining: DEPTH=4, Ready_i=0, push 0x11,0x22,0x33,0x44 on 4 edges -> Count_o 1,2,3,4; Ready_o=0 after 4th edge; 5th beat 0x55 held on Data_i is not accepted.
- Drain in order: from full, Ready_i=1, Valid_i=0 -> Data_o 0x11,0x22,0x33,0x44 on successive cycles; Valid_o=0 and Count_o=0 after 4th pop.
- Streaming with wrap: Valid_i=Ready_i=1 for 10 cycles with data 0x01..0x0A -> Count_o stays 1, Data_o lags Data_i by one cycle, pointers wrap past 3 with no loss.
- Full plus pop: at count=4 drive Valid_i=1, Ready_i=1 -> pop occurs, push refused, Count_o=3; next cycle push accepted and Count_o stays 3.
- Reset mid-operation: at count=2 pulse RESET_n low asynchronously between edges -> Valid_o=0 and Count_o=0 immediately; next push 0xA5 is the next Data_o. With FLOW_CTRL_BYPASS_EN: empty, Valid_i=Ready_i=1, Data_i=0x5A -> Data_o=0x5A in the same cycle, Count_o stays 0.
